// File: rtl/pseudo_color_lut_ctrl.sv
// Double-buffered gray->YUV palette: lookups read the active bank while the host fills the shadow bank.
// Optional PSEUDO_COLOR_BYPASS_EN adds bypass_i (MSB-aligned gray, neutral chroma) with the same 2-cycle latency.
module pseudo_color_lut_ctrl #(
  parameter int PIXEL_DATA_W = 8,
  parameter int DETAIL_LUT_W = 3,
  parameter int Y_DATA_W     = 8,
  parameter int U_DATA_W     = 8,
  parameter int V_DATA_W     = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 frame_start_i,
  input  logic                                 pix_valid_i,
  input  logic [PIXEL_DATA_W+DETAIL_LUT_W-1:0] data_lut_i,
`ifdef PSEUDO_COLOR_BYPASS_EN
  input  logic                                 bypass_i,
`endif
  output logic                                 pix_valid_o,
  output logic [Y_DATA_W-1:0]                  y_data_o,
  output logic [U_DATA_W-1:0]                  u_data_o,
  output logic [V_DATA_W-1:0]                  v_data_o,
  input  logic                                 load_start_i,
  input  logic                                 load_valid_i,
  input  logic [Y_DATA_W+U_DATA_W+V_DATA_W-1:0] load_data_i,
  output logic                                 load_ready_o,
  output logic                                 load_done_o,
  output logic                                 swap_pending_o,
  output logic                                 active_bank_o
);

  localparam int DATA_LUT_W = PIXEL_DATA_W + DETAIL_LUT_W;
  localparam int DEPTH      = 1 << DATA_LUT_W;
  localparam int YUV_DATA_W = Y_DATA_W + U_DATA_W + V_DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PEND} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_LUT_W-1:0]   r_wr_addr;
  logic                    r_active_bank;
  logic                    r_done;
  logic                    w_wr_en;
  logic                    w_last;
  logic                    w_swap;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [YUV_DATA_W-1:0]   r_ram [0:2*DEPTH-1];
  logic [YUV_DATA_W-1:0]   r_rd_dat;
  logic                    r_vld_s1;
  logic                    r_vld_o;
  logic [Y_DATA_W-1:0]     r_y;
  logic [U_DATA_W-1:0]     r_u;
  logic [V_DATA_W-1:0]     r_v;
  logic [Y_DATA_W-1:0]     w_y;
  logic [U_DATA_W-1:0]     w_u;
  logic [V_DATA_W-1:0]     w_v;

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_last      = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start_i) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_wr_en = load_valid_i;
        if (load_valid_i && (r_wr_addr == '1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (frame_start_i) begin
          w_swap      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= ST_IDLE;
      r_wr_addr     <= '0;
      r_done        <= 1'b0;
      r_active_bank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (r_state == ST_IDLE && load_start_i) r_wr_addr <= '0;
      else if (w_wr_en)                       r_wr_addr <= r_wr_addr + 1'b1;
      if (w_swap) r_active_bank <= ~r_active_bank;
    end
  end

  // Reads always use the active bank, writes always the other one, so they never collide.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) r_ram[{~r_active_bank, r_wr_addr}] <= load_data_i;
    r_rd_dat <= r_ram[{r_active_bank, data_lut_i}];
  end

`ifdef PSEUDO_COLOR_BYPASS_EN
  logic                r_byp_s1;
  logic [Y_DATA_W-1:0] r_gray_s1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_byp_s1  <= 1'b0;
      r_gray_s1 <= '0;
    end else begin
      r_byp_s1  <= bypass_i;
      r_gray_s1 <= data_lut_i[DATA_LUT_W-1 -: Y_DATA_W];
    end
  end

  always_comb begin
    w_y = r_rd_dat[YUV_DATA_W-1 -: Y_DATA_W];
    w_u = r_rd_dat[V_DATA_W +: U_DATA_W];
    w_v = r_rd_dat[V_DATA_W-1:0];
    if (r_byp_s1) begin
      w_y = r_gray_s1;
      w_u = {1'b1, {(U_DATA_W-1){1'b0}}};
      w_v = {1'b1, {(V_DATA_W-1){1'b0}}};
    end
  end
`else
  always_comb begin
    w_y = r_rd_dat[YUV_DATA_W-1 -: Y_DATA_W];
    w_u = r_rd_dat[V_DATA_W +: U_DATA_W];
    w_v = r_rd_dat[V_DATA_W-1:0];
  end
`endif

  // Data registers only load on valid pixels so the last colour is held between pixels.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld_s1 <= 1'b0;
      r_vld_o  <= 1'b0;
      r_y      <= '0;
      r_u      <= '0;
      r_v      <= '0;
    end else begin
      r_vld_s1 <= pix_valid_i;
      r_vld_o  <= r_vld_s1;
      if (r_vld_s1) begin
        r_y <= w_y;
        r_u <= w_u;
        r_v <= w_v;
      end
    end
  end

  assign pix_valid_o    = r_vld_o;
  assign y_data_o       = r_y;
  assign u_data_o       = r_u;
  assign v_data_o       = r_v;
  assign load_ready_o   = (r_state == ST_LOAD);
  assign load_done_o    = r_done;
  assign swap_pending_o = (r_state == ST_PEND);
  assign active_bank_o  = r_active_bank;

endmodule

// File: tb/tb_pseudo_color_lut_ctrl.sv
// Bench for pseudo_color_lut_ctrl: palette/bank model checked every cycle plus literal lookups.
module tb_pseudo_color_lut_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [10:0] data_lut_i = '0;
`ifdef PSEUDO_COLOR_BYPASS_EN
  logic        bypass_i = 1'b0;
`endif
  logic        pix_valid_o;
  logic [7:0]  y_data_o, u_data_o, v_data_o;
  logic        load_start_i = 1'b0;
  logic        load_valid_i = 1'b0;
  logic [23:0] load_data_i = '0;
  logic        load_ready_o, load_done_o, swap_pending_o, active_bank_o;

  int checks = 0;
  int failures = 0;
  int n_wr = 0;
  int n_done = 0;

  always #5 clk_i = ~clk_i;

  pseudo_color_lut_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .pix_valid_i(pix_valid_i), .data_lut_i(data_lut_i),
`ifdef PSEUDO_COLOR_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .pix_valid_o(pix_valid_o), .y_data_o(y_data_o), .u_data_o(u_data_o), .v_data_o(v_data_o),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_ready_o(load_ready_o), .load_done_o(load_done_o),
    .swap_pending_o(swap_pending_o), .active_bank_o(active_bank_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: two palette banks, host load progress, and the 2-cycle output pipe.
  logic [23:0] m_mem [0:4095];
  bit          m_known [0:4095];
  int          m_mode = 0;          // 0 idle, 1 loading, 2 waiting for frame start
  int          m_wr = 0;
  bit          m_active = 0;
  bit          m_done = 0;
  bit          m_s1_v = 0, m_s1_known = 1;
  logic [23:0] m_s1_d = '0;
  bit          m_o_v = 0, m_o_known = 1;
  logic [23:0] m_o_d = '0;

  always @(posedge clk_i or negedge rst_i) begin
    logic [11:0] a;
    if (!rst_i) begin
      m_mode = 0; m_wr = 0; m_active = 0; m_done = 0;
      m_s1_v = 0; m_o_v = 0; m_o_d = '0; m_o_known = 1;
    end else begin
      m_o_v = m_s1_v;
      if (m_s1_v) begin
        m_o_d = m_s1_d;
        m_o_known = m_s1_known;
      end
      m_s1_v = pix_valid_i;
      a = {m_active, data_lut_i};
      m_s1_d = m_mem[a];
      m_s1_known = m_known[a];
`ifdef PSEUDO_COLOR_BYPASS_EN
      if (bypass_i) begin
        m_s1_d = {data_lut_i[10:3], 8'h80, 8'h80};
        m_s1_known = 1;
      end
`endif
      m_done = 0;
      case (m_mode)
        0: if (load_start_i) begin m_mode = 1; m_wr = 0; end
        1: if (load_valid_i) begin
             a = {~m_active, m_wr[10:0]};
             m_mem[a] = load_data_i;
             m_known[a] = 1;
             if (m_wr == 2047) begin m_mode = 2; m_done = 1; end
             m_wr++;
           end
        default: if (frame_start_i) begin m_active = ~m_active; m_mode = 0; end
      endcase
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("rst_pix_valid", pix_valid_o, 0);
      chk("rst_yuv", {y_data_o, u_data_o, v_data_o}, 0);
      chk("rst_ready", load_ready_o, 0);
      chk("rst_done", load_done_o, 0);
      chk("rst_pending", swap_pending_o, 0);
      chk("rst_bank", active_bank_o, 0);
    end else begin
      chk("pix_valid", pix_valid_o, m_o_v);
      if (m_o_known) chk("yuv", {y_data_o, u_data_o, v_data_o}, m_o_d);
      chk("load_ready", load_ready_o, m_mode == 1);
      chk("load_done", load_done_o, m_done);
      chk("swap_pending", swap_pending_o, m_mode == 2);
      chk("active_bank", active_bank_o, m_active);
      if (load_valid_i && load_ready_o) n_wr++;
      if (load_done_o) n_done++;
    end
  end

  function automatic logic [23:0] pat_word(input int p, input int k);
    logic [10:0] i;
    i = k[10:0];
    case (p)
      0:       return {i[7:0], 8'h40, 8'hC0};
      1:       return {8'h5A, i[7:0], 8'h0F};
      2:       return {~i[7:0], 8'h11, 8'h22};
      default: return {8'h77, i[10:3], i[7:0]};
    endcase
  endfunction

  // All tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start_i = 1;
    @(posedge clk_i); #1;
    frame_start_i = 0;
  endtask

  task automatic lookup_lit(input string name, input logic [10:0] idx,
                            input logic [7:0] ey, input logic [7:0] eu, input logic [7:0] ev);
    pix_valid_i = 0;
    idle(2);
    pix_valid_i = 1; data_lut_i = idx;
    @(posedge clk_i); #1;
    pix_valid_i = 0;
    @(negedge clk_i);
    chk({name, "_vld_cycle1"}, pix_valid_o, 0);
    @(negedge clk_i);
    chk({name, "_vld_cycle2"}, pix_valid_o, 1);
    chk({name, "_y"}, y_data_o, ey);
    chk({name, "_u"}, u_data_o, eu);
    chk({name, "_v"}, v_data_o, ev);
    @(posedge clk_i); #1;
  endtask

  task automatic do_load(input int pat, input bit throttle, input bit fs_last,
                         input int restart_at, input int abort_at);
    int  k;
    int  guard;
    bit  vld;
    load_start_i = 1;
    @(posedge clk_i); #1;
    load_start_i = 0;
    n_wr = 0; n_done = 0;
    k = 0; guard = 0;
    while (k < 2048 && guard < 8000) begin
      guard++;
      if (k == abort_at) begin
        load_valid_i = 0; pix_valid_i = 0;
        rst_i = 0;
        idle(2);
        rst_i = 1;
        break;
      end
      vld = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
      load_valid_i  = vld;
      load_data_i   = pat_word(pat, k);
      load_start_i  = (k == restart_at);
      frame_start_i = fs_last && vld && (k == 2047);
      pix_valid_i   = ($urandom_range(0, 1) == 1);
      data_lut_i    = 11'($urandom_range(0, 2047));
      @(negedge clk_i);
      if (!load_ready_o) begin
        failures++;
        $display("FAIL load_ready_during_load: got 0 expected 1 at word %0d", k);
        break;
      end
      if (vld) k++;
      @(posedge clk_i); #1;
    end
    if (guard >= 8000) begin
      failures++;
      $display("FAIL load_timeout: got %0d words expected 2048", k);
    end
    load_valid_i = 0; load_start_i = 0; frame_start_i = 0; pix_valid_i = 0;
  endtask

  initial begin
    // Reset held with random inputs toggling.
    repeat (4) begin
      @(posedge clk_i); #1;
      frame_start_i = ($urandom_range(0, 1) == 1);
      pix_valid_i   = ($urandom_range(0, 1) == 1);
      data_lut_i    = 11'($urandom_range(0, 2047));
      load_start_i  = ($urandom_range(0, 1) == 1);
      load_valid_i  = ($urandom_range(0, 1) == 1);
      load_data_i   = 24'($urandom);
    end
    frame_start_i = 0; pix_valid_i = 0; load_start_i = 0; load_valid_i = 0;
    rst_i = 1;
    idle(3);
    chk("post_rst_valid", pix_valid_o, 0);
    chk("post_rst_y", y_data_o, 0);
    chk("post_rst_bank", active_bank_o, 0);

    // Fill bank 1; bank 0 stays active until a frame start.
    do_load(0, 0, 0, -1, -1);
    idle(3);
    chk("t2_bank_before_swap", active_bank_o, 0);
    chk("t2_pending", swap_pending_o, 1);
    chk("t2_writes", n_wr, 2048);
    chk("t2_done_pulses", n_done, 1);
    frame_pulse();
    chk("t2_bank_after_swap", active_bank_o, 1);
    chk("t2_pending_cleared", swap_pending_o, 0);
    lookup_lit("t2_0x123", 11'h123, 8'h23, 8'h40, 8'hC0);

    // Throttled load of bank 0 while bank 1 serves lookups.
    do_load(1, 1, 0, -1, -1);
    idle(3);
    chk("t3_writes", n_wr, 2048);
    chk("t3_done_pulses", n_done, 1);
    chk("t3_ready_low", load_ready_o, 0);
    chk("t3_pending", swap_pending_o, 1);
    lookup_lit("t3_old_bank", 11'h123, 8'h23, 8'h40, 8'hC0);
    frame_pulse();
    lookup_lit("t3_new_bank", 11'h123, 8'h5A, 8'h23, 8'h0F);

    // Frame start coinciding with the last word must not swap.
    do_load(2, 0, 1, -1, -1);
    idle(3);
    chk("t4_no_swap_bank", active_bank_o, 0);
    chk("t4_pending", swap_pending_o, 1);
    lookup_lit("t4_still_old", 11'h123, 8'h5A, 8'h23, 8'h0F);
    frame_pulse();
    chk("t4_swapped_bank", active_bank_o, 1);
    lookup_lit("t4_new_bank", 11'h123, 8'hDC, 8'h11, 8'h22);

    // Restart request mid-load is ignored.
    do_load(3, 0, 0, 100, -1);
    idle(3);
    chk("t5_writes", n_wr, 2048);
    chk("t5_done_pulses", n_done, 1);
    frame_pulse();
    chk("t5_bank", active_bank_o, 0);
    lookup_lit("t5_bank0", 11'h123, 8'h77, 8'h24, 8'h23);

    // Reset mid-load discards the load.
    do_load(0, 0, 0, -1, 500);
    idle(2);
    chk("t5r_bank", active_bank_o, 0);
    chk("t5r_ready", load_ready_o, 0);
    chk("t5r_pending", swap_pending_o, 0);
    lookup_lit("t5r_bank0", 11'h123, 8'h77, 8'h24, 8'h23);

`ifdef PSEUDO_COLOR_BYPASS_EN
    bypass_i = 1;
    lookup_lit("t6_bypass", 11'h5A7, 8'hB4, 8'h80, 8'h80);
    bypass_i = 0;
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
